// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: boot FSM, fetch-priority grant, 1-cycle read response routing.
// Optional load anti-starvation forced grant is enabled by defining IMEM_ARB_STARVE_EN.
module imem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  PC,
  input  logic                  rst,
  input  logic                  boot_done,
  input  logic                  fetch_req_valid,
  output logic                  fetch_req_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_rsp_valid,
  output logic [DATA_WIDTH-1:0] fetch_rsp_data,
  input  logic                  load_req_valid,
  output logic                  load_req_ready,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  output logic                  load_rsp_valid,
  output logic [DATA_WIDTH-1:0] load_rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  boot_mode
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  tag_vld_q, tag_vld_d;
  logic                  tag_ld_q, tag_ld_d;
  logic [DATA_WIDTH-1:0] fdata_q, ldata_q;
  logic                  run, force_ld, fetch_gnt, load_gnt;

`ifdef IMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (load_gnt)
      starve_d = '0;
    else if (run && load_req_valid && starve_q != LIMIT)
      starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge PC or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  assign force_ld = run & load_req_valid & (starve_q == LIMIT);
`else
  assign force_ld = 1'b0;
`endif

  // Grants are gated by rst so both readies read 0 while reset is held.
  always_comb begin
    run       = (state_q == RUN);
    fetch_gnt = rst & run & fetch_req_valid & ~force_ld;
    load_gnt  = rst & load_req_valid & ~fetch_gnt;
    tag_vld_d = fetch_gnt | (load_gnt & ~load_we);
    tag_ld_d  = load_gnt;
    mem_addr  = addr_q;
    if (fetch_gnt)     mem_addr = fetch_addr;
    else if (load_gnt) mem_addr = load_addr;
  end

  assign fetch_req_ready = fetch_gnt;
  assign load_req_ready  = load_gnt;
  assign mem_we          = load_gnt & load_we;
  assign mem_din         = load_wdata;
  assign boot_mode       = (state_q == BOOT);

  assign fetch_rsp_valid = tag_vld_q & ~tag_ld_q;
  assign load_rsp_valid  = tag_vld_q & tag_ld_q;
  assign fetch_rsp_data  = fetch_rsp_valid ? mem_dout : fdata_q;
  assign load_rsp_data   = load_rsp_valid  ? mem_dout : ldata_q;

  always_ff @(posedge PC or negedge rst) begin
    if (!rst) begin
      state_q   <= BOOT;
      addr_q    <= '0;
      tag_vld_q <= 1'b0;
      tag_ld_q  <= 1'b0;
      fdata_q   <= '0;
      ldata_q   <= '0;
    end else begin
      if (state_q == BOOT && boot_done) state_q <= RUN;
      addr_q    <= mem_addr;
      tag_vld_q <= tag_vld_d;
      tag_ld_q  <= tag_ld_d;
      fdata_q   <= fetch_rsp_data;
      ldata_q   <= load_rsp_data;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed table-driven bench for imem_arbiter with a registered-read memory model.
module tb_imem_arbiter;

  logic       PC = 1'b0;
  logic       rst;
  logic       boot_done, fetch_req_valid, load_req_valid, load_we;
  logic [7:0] fetch_addr, load_addr, load_wdata;
  logic       fetch_req_ready, fetch_rsp_valid, load_req_ready, load_rsp_valid;
  logic [7:0] fetch_rsp_data, load_rsp_data, mem_addr, mem_din, mem_dout;
  logic       mem_we, boot_mode;

  logic [7:0] mem [256];
  int         errors = 0;
  int         checks = 0;

  always #5 PC = ~PC;

  imem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
    .PC(PC), .rst(rst), .boot_done(boot_done),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_addr(fetch_addr), .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_data(fetch_rsp_data), .load_req_valid(load_req_valid),
    .load_req_ready(load_req_ready), .load_we(load_we), .load_addr(load_addr),
    .load_wdata(load_wdata), .load_rsp_valid(load_rsp_valid),
    .load_rsp_data(load_rsp_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout), .boot_mode(boot_mode)
  );

  // Memory with one-cycle registered read.
  always @(posedge PC) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  typedef struct {
    logic       bd, fv;
    logic [7:0] fa;
    logic       lv, lwe;
    logic [7:0] la, lwd;
    logic       frdy, lrdy, mwe;
    logic [7:0] maddr;
    logic       fvld;
    logic [7:0] fdat;
    logic       lvld;
    logic [7:0] ldat;
    logic       bmode;
  } vec_t;

  vec_t vec [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic bd, input logic fv, input logic [7:0] fa,
                        input logic lv, input logic lwe, input logic [7:0] la,
                        input logic [7:0] lwd);
    boot_done = bd; fetch_req_valid = fv; fetch_addr = fa;
    load_req_valid = lv; load_we = lwe; load_addr = la; load_wdata = lwd;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " fetch_ready"}, fetch_req_ready, 0);
    chk({tag, " load_ready"},  load_req_ready, 0);
    chk({tag, " mem_we"},      mem_we, 0);
    chk({tag, " mem_addr"},    mem_addr, 0);
    chk({tag, " fetch_vld"},   fetch_rsp_valid, 0);
    chk({tag, " fetch_dat"},   fetch_rsp_data, 0);
    chk({tag, " load_vld"},    load_rsp_valid, 0);
    chk({tag, " load_dat"},    load_rsp_data, 0);
    chk({tag, " boot_mode"},   boot_mode, 1);
  endtask

  initial begin
    bit forced;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[5] = 8'h77;

    //         bd fv fa     lv lwe la     lwd    frdy lrdy mwe maddr  fvld fdat   lvld ldat   bm
    vec[0]  = '{0, 1, 8'h03, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1};
    vec[1]  = '{0, 1, 8'h03, 1, 1, 8'h10, 8'hA5, 0, 1, 1, 8'h10, 0, 8'h00, 0, 8'h00, 1};
    vec[2]  = '{0, 1, 8'h05, 1, 0, 8'h10, 8'h00, 0, 1, 0, 8'h10, 0, 8'h00, 0, 8'h00, 1};
    vec[3]  = '{1, 1, 8'h01, 1, 0, 8'h10, 8'h00, 0, 1, 0, 8'h10, 0, 8'h00, 1, 8'hA5, 1};
    vec[4]  = '{0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 0, 8'h00, 1, 8'hA5, 0};
    vec[5]  = '{0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 8'hA5, 0, 8'hA5, 0};
    vec[6]  = '{0, 1, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 1, 8'h11, 0, 8'hA5, 0};
    vec[7]  = '{0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 1, 8'h22, 0, 8'hA5, 0};
    vec[8]  = '{0, 0, 8'h07, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h02, 1, 8'h33, 0, 8'hA5, 0};
    vec[9]  = '{0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h02, 0, 8'h33, 0, 8'hA5, 0};
    vec[10] = '{0, 0, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 1, 1, 8'h20, 0, 8'h33, 0, 8'hA5, 0};
    vec[11] = '{0, 1, 8'h20, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 0, 8'h33, 0, 8'hA5, 0};
    vec[12] = '{0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h20, 1, 8'h3C, 0, 8'hA5, 0};
    vec[13] = '{1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h20, 0, 8'h3C, 0, 8'hA5, 0};

    // Reset held with both requesters active: readies must stay low.
    rst = 1'b0;
    set_in(0, 1, 8'h44, 1, 1, 8'h55, 8'h66);
    @(negedge PC); @(negedge PC);
    chk_reset_vals("reset");
    @(posedge PC); #1;
    rst = 1'b1;
    set_in(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);

    for (int i = 0; i < 14; i++) begin
      @(posedge PC); #1;
      set_in(vec[i].bd, vec[i].fv, vec[i].fa, vec[i].lv, vec[i].lwe, vec[i].la, vec[i].lwd);
      @(negedge PC);
      chk($sformatf("v%0d fetch_ready", i), fetch_req_ready, vec[i].frdy);
      chk($sformatf("v%0d load_ready", i),  load_req_ready,  vec[i].lrdy);
      chk($sformatf("v%0d mem_we", i),      mem_we,          vec[i].mwe);
      chk($sformatf("v%0d mem_addr", i),    mem_addr,        vec[i].maddr);
      chk($sformatf("v%0d fetch_vld", i),   fetch_rsp_valid, vec[i].fvld);
      chk($sformatf("v%0d fetch_dat", i),   fetch_rsp_data,  vec[i].fdat);
      chk($sformatf("v%0d load_vld", i),    load_rsp_valid,  vec[i].lvld);
      chk($sformatf("v%0d load_dat", i),    load_rsp_data,   vec[i].ldat);
      chk($sformatf("v%0d boot_mode", i),   boot_mode,       vec[i].bmode);
    end

    // Contention: fetch read of 0x05 and load read of 0x10 held together.
    for (int c = 1; c <= 10; c++) begin
      @(posedge PC); #1;
      set_in(0, 1, 8'h05, 1, 0, 8'h10, 8'h00);
      @(negedge PC);
`ifdef IMEM_ARB_STARVE_EN
      forced = (c == 5 || c == 10);
      if (c == 6) begin
        chk("starve rsp_vld", load_rsp_valid, 1);
        chk("starve rsp_dat", load_rsp_data, 8'hA5);
      end
`else
      forced = 1'b0;
`endif
      chk($sformatf("cont c%0d fetch_ready", c), fetch_req_ready, !forced);
      chk($sformatf("cont c%0d load_ready", c),  load_req_ready, forced);
      chk($sformatf("cont c%0d mem_addr", c),    mem_addr, forced ? 8'h10 : 8'h05);
    end
    @(posedge PC); #1;
    set_in(0, 0, 8'h00, 1, 0, 8'h10, 8'h00);
    @(negedge PC);
    chk("cont drop fetch_ready", fetch_req_ready, 0);
    chk("cont drop load_ready", load_req_ready, 1);
    @(posedge PC); #1;
    set_in(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge PC);
    chk("cont load rsp_vld", load_rsp_valid, 1);
    chk("cont load rsp_dat", load_rsp_data, 8'hA5);
    chk("cont fetch rsp_vld", fetch_rsp_valid, 0);

    // Reset asserted while a fetch read is in flight.
    @(posedge PC); #1;
    set_in(0, 1, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge PC);
    chk("midrst accept", fetch_req_ready, 1);
    #1;
    rst = 1'b0;
    set_in(0, 1, 8'h00, 1, 1, 8'h30, 8'h99);
    #1;
    chk_reset_vals("midrst");
    @(negedge PC);
    chk_reset_vals("midrst hold");
    @(posedge PC); #1;
    rst = 1'b1;
    set_in(0, 1, 8'h01, 0, 0, 8'h00, 8'h00);
    for (int c = 0; c < 2; c++) begin
      @(negedge PC);
      chk($sformatf("postrst%0d fetch_vld", c), fetch_rsp_valid, 0);
      chk($sformatf("postrst%0d load_vld", c),  load_rsp_valid, 0);
      chk($sformatf("postrst%0d boot_mode", c), boot_mode, 1);
      chk($sformatf("postrst%0d fetch_ready", c), fetch_req_ready, 0);
      @(posedge PC); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single instruction-memory port between the CPU fetch stage and the program-load/debug port. A boot FSM holds fetch off until loading completes, then gives fetch priority and services loads in idle cycles. It also tracks the memory's one-cycle registered read latency and routes each read result back to the requester that issued it. It sits directly in front of the instruction memory, driving its address, write-enable and write-data, and taking its registered read data.

## Interface
- ADDR_WIDTH, 8, instruction-memory address width
- DATA_WIDTH, 8, instruction-memory word width
- STARVE_LIMIT, 4, RUN-state cycles a waiting load may be denied before forced grant (≥1)

- PC  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- boot_done  in  1  single-cycle pulse: program load complete
- fetch_req_valid  in  1  fetch read request
- fetch_req_ready  out  1  fetch request accepted this cycle
- fetch_addr  in  ADDR_WIDTH  fetch read address
- fetch_rsp_valid  out  1  fetch read data valid (1-cycle pulse)
- fetch_rsp_data  out  DATA_WIDTH  fetch read data
- load_req_valid  in  1  load-port request
- load_req_ready  out  1  load request accepted this cycle
- load_we  in  1  1 = write, 0 = read
- load_addr  in  ADDR_WIDTH  load-port address
- load_wdata  in  DATA_WIDTH  load-port write data
- load_rsp_valid  out  1  load read data valid (1-cycle pulse; reads only)
- load_rsp_data  out  DATA_WIDTH  load read data
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  1  memory write enable
- mem_din  out  DATA_WIDTH  memory write data
- mem_dout  in  DATA_WIDTH  memory registered read data; valid one cycle after the address
- boot_mode  out  1  1 while the FSM is in BOOT

## Operation
- FSM states: BOOT (reset state) and RUN.
- BOOT → RUN on boot_done=1. RUN has no return path; only rst returns the FSM to BOOT.
- BOOT:
  - fetch_req_ready=0.
  - load_req_ready=load_req_valid.
- RUN grant:
  - If fetch_req_valid=1, fetch is granted, except on a forced load grant.
  - Otherwise, if load_req_valid=1, load is granted.
  - At most one grant per cycle. ready is the combinational grant.
- A request is accepted when valid & ready.
- Memory drive for the granted requester:
  - mem_addr = the requester's address.
  - mem_we = 1 only for an accepted load write.
  - mem_din = load_wdata.
- With no grant: mem_addr holds its last value, mem_we=0.
- Accepting a read sets a registered response tag (owner + valid). The following cycle:
  - the owner's rsp_valid=1;
  - the owner's rsp_data = mem_dout;
  - the tag clears unless a new read is accepted.
- Writes never set the tag.
- Back-to-back reads are supported: one accepted read per cycle, each returning exactly one cycle later.
- rsp_data holds the last returned value when rsp_valid=0.
- Simultaneous events:
  - boot_done arriving with a pending BOOT load: the load completes normally, and RUN grants begin the next cycle.
  - boot_done in RUN is ignored.
- Reset values (async, while rst=0):
  - FSM=BOOT, tag cleared, starvation counter=0.
  - fetch_rsp_valid=0, load_rsp_valid=0.
  - rsp_data=0, mem_addr=0.
  - Both readies=0, mem_we=0, boot_mode=1.
- Reset mid-operation: a pending response is discarded, and no rsp_valid pulse is issued after reset release.

## Timing
- Request-to-response latency: exactly 1 cycle (response cycle N+1 for acceptance in cycle N).
- Grant and ready are combinational from the valids and registered state; no ready-to-ready combinational path.
- Accepted writes are committed by the memory at the PC edge ending the acceptance cycle.
- Throughput: 1 access per cycle.
- Fetch stall: 0 cycles when no forced load grant is pending.

## Configuration
- IMEM_ARB_STARVE_EN defined:
  - Counter width is $clog2(STARVE_LIMIT+1).
  - In RUN, the counter increments each cycle load_req_valid=1 and load is not granted, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT, the load is granted over fetch; fetch_req_ready=0 that cycle.
  - The counter clears on any load acceptance.
- Not defined:
  - No counter logic.
  - Strict fetch priority in RUN; a load may be starved indefinitely.

## Test plan
- Reset: drive rst=0 mid-read → all outputs at reset values; after release, no rsp pulse, boot_mode=1, fetch_req_ready=0 with fetch_req_valid=1.
- Boot load:
  - In BOOT, write 0xA5 to address 0x10 via the load port; boot_done pulse; fetch read of 0x10 → fetch_rsp_valid one cycle later with data 0xA5.
  - Fetch requests before boot_done are never accepted.
- Back-to-back fetch: fetch reads of addresses 0,1,2 in consecutive cycles → three consecutive fetch_rsp_valid pulses with the matching words, in order.
- Contention: in RUN, fetch_req_valid and a load read held at 1 → fetch granted every cycle; the load is accepted only when fetch drops (macro undefined).
- Starvation (IMEM_ARB_STARVE_EN, STARVE_LIMIT=4): continuous fetch plus a load read → load accepted in the 5th cycle, fetch_req_ready=0 that cycle, load_rsp_valid the next cycle, counter back to 0.
- Mixed routing: alternating load write (0x3C→0x20) then fetch read 0x20 → fetch_rsp_data=0x3C; load_rsp_valid never asserted for the write.
